// File: rtl/piso_tx_pkg.sv
// Shared definitions for the PISO transmit controller.
// Build option: define PISO_TX_PARITY_EN to add the even-parity cycle.
package piso_tx_pkg;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 3;

  // Index of the final data bit in a frame, and a counter increment.
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

`ifdef PISO_TX_PARITY_EN
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_SHIFT  = 2'd2,
    ST_PARITY = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } state_e;
`endif

endpackage

// File: rtl/piso_tx_controller.sv
// Controller for an external 8-bit PISO shift register. It accepts bytes
// with a valid/ready handshake, drives the PISO load/shift select and
// parallel input, and reports frame progress. All outputs except
// Frame_Done_Out decode from registered state only, so they settle early
// in the cycle, ahead of the PISO's falling-edge sample.
// Build option: PISO_TX_PARITY_EN adds a PARITY cycle after bit 7 that
// presents the even-parity bit of the held byte. Without it the parity
// outputs are tied low and the PARITY state does not exist.
module piso_tx_controller
  import piso_tx_pkg::*;
(
  input  logic              Clk_In,
  input  logic              Reset_In,
  input  logic              Data_Valid_In,
  input  logic [DATA_W-1:0] Data_In,
  output logic              Data_Ready_Out,
  output logic              Load_Shiftb_Out,
  output logic [DATA_W-1:0] Parallel_Data_Out,
  output logic              Frame_Active_Out,
  output logic [CNT_W-1:0]  Bit_Index_Out,
  output logic              Frame_Done_Out,
  output logic              Parity_Bit_Out,
  output logic              Parity_Phase_Out
);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   hold_q, hold_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                done_q, done_d;

  logic                last_bit;
  logic                frame_end;
  logic                xfer;

  assign last_bit = (state_q == ST_SHIFT) && (cnt_q == LAST_IDX);

`ifdef PISO_TX_PARITY_EN
  // The parity cycle closes the frame and is where the next byte is taken.
  assign frame_end        = (state_q == ST_PARITY);
  assign Data_Ready_Out   = (state_q == ST_IDLE) || (state_q == ST_PARITY);
  assign Parity_Phase_Out = (state_q == ST_PARITY);
  assign Parity_Bit_Out   = (state_q == ST_PARITY) ? (^hold_q) : 1'b0;
`else
  // Bit 7 closes the frame; taking the next byte there gives a zero gap.
  assign frame_end        = last_bit;
  assign Data_Ready_Out   = (state_q == ST_IDLE) || last_bit;
  assign Parity_Phase_Out = 1'b0;
  assign Parity_Bit_Out   = 1'b0;
`endif

  assign xfer = Data_Valid_In && Data_Ready_Out;

  // Moore decode of the PISO controls; the PISO loads zero whenever it is
  // not loading a data byte or shifting, which keeps the line low.
  assign Load_Shiftb_Out   = (state_q != ST_SHIFT);
  assign Parallel_Data_Out = (state_q == ST_LOAD) ? hold_q : '0;
  assign Frame_Active_Out  = (state_q == ST_LOAD) || (state_q == ST_SHIFT);
  assign Bit_Index_Out     = Frame_Active_Out ? cnt_q : '0;
  assign Frame_Done_Out    = done_q;

  // Next-state logic: frame sequencing, bit counter and byte capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = xfer ? Data_In : hold_q;
    done_d  = frame_end;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (xfer) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        state_d = ST_SHIFT;
        cnt_d   = CNT_ONE;
      end
      ST_SHIFT: begin
        if (last_bit) begin
          cnt_d = '0;
`ifdef PISO_TX_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d = xfer ? ST_LOAD : ST_IDLE;
`endif
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
`ifdef PISO_TX_PARITY_EN
      ST_PARITY: begin
        cnt_d   = '0;
        state_d = xfer ? ST_LOAD : ST_IDLE;
      end
`endif
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers; reset abandons any frame and drops a pending done pulse.
  always_ff @(posedge Clk_In) begin
    if (Reset_In) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: doc/piso_tx_controller.md
PISO_TX_CONTROLLER -- requirements
Module: piso_tx_controller

Interface
REQ-001 Clk_In  input  1  single clock; all state SHALL update on its rising edge.
REQ-002 Reset_In  input  1  reset; synchronous and active-high.
REQ-003 Data_Valid_In  input  1  upstream byte offered.
REQ-004 Data_In  input  8  upstream byte; bit 0 is sent first.
REQ-005 Data_Ready_Out  output  1  controller accepts a byte this cycle.
REQ-006 Load_Shiftb_Out  output  1  drives the 8-bit PISO load/shift select; 1 = load, 0 = shift.
REQ-007 Parallel_Data_Out  output  8  drives the PISO parallel input.
REQ-008 Frame_Active_Out  output  1  high during every data-bit cycle.
REQ-009 Bit_Index_Out  output  3  index of the bit on the serial line this cycle.
REQ-010 Frame_Done_Out  output  1  one-cycle pulse after a frame completes.
REQ-011 Parity_Bit_Out  output  1  even-parity bit; valid only in PARITY.
REQ-012 Parity_Phase_Out  output  1  high in PARITY.

Function
REQ-013 The FSM SHALL have states IDLE, LOAD and SHIFT, plus PARITY when the macro in REQ-027 is defined.
- All outputs except Frame_Done_Out SHALL decode from registered state only (Moore outputs).
- The PISO samples on the falling clock edge, so these outputs must be stable before mid-cycle.
REQ-014 A byte is transferred when Data_Valid_In=1 and Data_Ready_Out=1 at a rising edge; Data_In SHALL be latched into an 8-bit holding register.
REQ-015 Data_Ready_Out SHALL be 1 in these cycles and 0 in all others:
- in IDLE;
- in the last SHIFT cycle (index 7) when parity is compiled out;
- in PARITY when parity is compiled in.
REQ-016 IDLE: Load_Shiftb_Out=1, Parallel_Data_Out=0x00, so the serial line idles low. On transfer, next state SHALL be LOAD.
REQ-017 LOAD: one cycle; Load_Shiftb_Out=1, Parallel_Data_Out=holding register, Bit_Index_Out=0, Frame_Active_Out=1. Next state SHALL be SHIFT.
REQ-018 SHIFT: seven cycles; Load_Shiftb_Out=0, Bit_Index_Out counts 1..7, Frame_Active_Out=1.
- Serial bit i SHALL be valid at the rising edge that ends the cycle with Bit_Index_Out=i.
REQ-019 After index 7 the next state SHALL be:
- PARITY if parity is compiled in;
- otherwise LOAD if a transfer occurred at that edge;
- otherwise IDLE.
REQ-020 PARITY: one cycle; Load_Shiftb_Out=1, Parallel_Data_Out=0x00, Parity_Phase_Out=1, Parity_Bit_Out=XOR of the held byte, Frame_Active_Out=0.
- Next state SHALL be LOAD on transfer, else IDLE.
REQ-021 Frame_Done_Out SHALL pulse for one cycle in the cycle after the final frame cycle (index 7, or PARITY).
- When frames run back-to-back, this pulse coincides with the next LOAD.
REQ-022 Back-to-back frames SHALL have zero idle cycles between them.
REQ-023 A transfer is impossible while Data_Ready_Out=0; Data_Valid_In during those cycles SHALL be ignored and the byte held upstream.
REQ-024 Bit_Index_Out SHALL be 0 outside LOAD/SHIFT.

Reset
REQ-025 Reset_In=1 at a rising edge SHALL force all of the following, overriding any transfer in the same cycle:
- state IDLE, holding register 0x00, bit counter 0;
- Frame_Done_Out=0, Parity_Bit_Out=0, Parity_Phase_Out=0;
- Data_Ready_Out=1, Load_Shiftb_Out=1, Parallel_Data_Out=0x00.
REQ-026 Reset mid-frame SHALL abandon the frame with no Frame_Done_Out pulse; the next frame SHALL start from LOAD.

Configuration
REQ-027 Macro PISO_TX_PARITY_EN: when defined, the PARITY state and parity logic SHALL be compiled in.
- When undefined, PARITY SHALL be absent and Parity_Bit_Out and Parity_Phase_Out SHALL be tied 0.
- Ports SHALL be identical in both builds.

Structure
REQ-028 Package piso_tx_pkg SHALL hold the state enum, DATA_W=8 and CNT_W=3.
REQ-029 No sub-module; the block SHALL be instantiated beside the existing 8-bit PISO at the same level and drive its load/shift select and parallel input directly.

Verification
REQ-030 After reset, offer 0xA5 -> accepted at edge T0; LOAD at T0+1; serial samples 1,0,1,0,0,1,0,1 at edges ending indices 0..7; Frame_Done_Out=1 in cycle T0+9 with parity off.
REQ-031 Data_Valid_In held high with 0x3C then 0xC3 -> second byte accepted in the index-7 cycle; its LOAD follows immediately with zero gap; Frame_Done_Out coincides with that LOAD.
REQ-032 Data_Valid_In toggled during SHIFT -> no acceptance; the held byte is unchanged; the serial bit sequence is unaffected.
REQ-033 Reset_In asserted at index 4 of 0xFF -> next cycle IDLE, Load_Shiftb_Out=1, Parallel_Data_Out=0x00, no Frame_Done_Out pulse.
REQ-034 With PISO_TX_PARITY_EN defined: send 0xA5 -> PARITY cycle with Parity_Bit_Out=0; send 0x07 -> Parity_Bit_Out=1; Frame_Done_Out one cycle later than with parity off.
REQ-035 Idle with no valid for 20 cycles -> Load_Shiftb_Out=1, serial line 0, Frame_Active_Out=0 throughout.
